// File: rtl/minority_resp_checker_pkg.sv
// Shared types and golden function for the minority response checker.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package minority_chk_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        ACCEPT  = 3'd1,
        SETTLE  = 3'd2,
        COMPARE = 3'd3,
        DONE    = 3'd4
    } state_t;

    // Every one of the eight abc values has been checked at least once.
    localparam logic [7:0] ALL_COVERED = 8'hFF;

    // Minority of three: high when fewer than two inputs are high.
    function automatic logic minority_f(input logic [2:0] v);
        return ~((v[2] & v[1]) | (v[2] & v[0]) | (v[1] & v[0]));
    endfunction

endpackage

// File: rtl/minority_resp_checker_ref.sv
// Combinational golden minority model used as the expected response.
// Latency: 0 cycles (pure combinational).
// Backpressure: none; always produces y_exp for the presented abc.
//
// Ports:
//   i_abc    {a,b,c} vector under check
//   o_y_exp  expected minority output
module minority_ref
    import minority_chk_pkg::*;
(
    input  logic [2:0] i_abc,
    output logic       o_y_exp
);

    assign o_y_exp = minority_f(i_abc);

endmodule

// File: rtl/minority_resp_checker.sv
// Response checker for a 3-input minority DUT: handshakes vectors, waits, compares, keeps stats.
// Latency: result of a vector lands SETTLE_CYCLES+1 edges after its handshake; SETTLE_CYCLES+2 cycles per vector.
// Backpressure: in_ready is high only in ACCEPT; abc must stay stable until in_ready returns high.
//
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   start             one-cycle run start (honoured in IDLE and DONE only)
//   in_valid/in_ready vector handshake; abc is the vector driven into the DUT
//   y_dut             DUT output sampled in COMPARE
//   busy, done, pass  run status; pass qualified by done
//   err_count         saturating mismatch count
//   vec_count         vectors checked this run
//   coverage          bit i set once abc==i has been checked
//   first_fail_*      abc of the first mismatch and its valid flag
module minority_resp_checker
    import minority_chk_pkg::*;
#(
    parameter int NUM_VECTORS   = 8,
    parameter int SETTLE_CYCLES = 1,
    parameter int ERR_W         = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       abc,
    input  logic             y_dut,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [ERR_W-1:0] err_count,
    output logic [7:0]       vec_count,
    output logic [7:0]       coverage,
    output logic             first_fail_valid,
    output logic [2:0]       first_fail_vec
);

    localparam logic [7:0] LAST_VEC    = 8'(NUM_VECTORS);
    localparam logic [3:0] SETTLE_LAST = (SETTLE_CYCLES > 0) ? 4'(SETTLE_CYCLES - 1) : 4'd0;
    // With fewer than eight vectors full coverage is unreachable, so only errors count.
    localparam bit         NEED_FULL_COV = (NUM_VECTORS >= 8);

    state_t           r_state;
    state_t           w_state_nxt;
    logic [2:0]       r_vec_q;
    logic [3:0]       r_settle_cnt;
    logic [ERR_W-1:0] r_err_cnt;
    logic [7:0]       r_vec_cnt;
    logic [7:0]       r_cov;
    logic             r_ff_vld;
    logic [2:0]       r_ff_vec;

    logic             w_hs;
    logic             w_clear;
    logic             w_y_exp;
    logic             w_mismatch;
    logic [7:0]       w_vec_cnt_inc;
    logic             w_last;

    minority_ref u_ref (
        .i_abc   (r_vec_q),
        .o_y_exp (w_y_exp)
    );

    assign w_hs          = (r_state == ACCEPT) && in_valid;
    assign w_clear       = start && ((r_state == IDLE) || (r_state == DONE));
    assign w_mismatch    = (r_state == COMPARE) && (y_dut != w_y_exp);
    assign w_vec_cnt_inc = r_vec_cnt + 8'd1;
    assign w_last        = (w_vec_cnt_inc == LAST_VEC);

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            IDLE, DONE: begin
                if (start) w_state_nxt = ACCEPT;
            end
            ACCEPT: begin
                if (in_valid) w_state_nxt = (SETTLE_CYCLES > 0) ? SETTLE : COMPARE;
            end
            SETTLE: begin
                if (r_settle_cnt == SETTLE_LAST) w_state_nxt = COMPARE;
            end
            COMPARE: begin
                w_state_nxt = w_last ? DONE : ACCEPT;
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    // Vector capture and settle timer
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_vec_q      <= 3'd0;
            r_settle_cnt <= 4'd0;
        end else begin
            if (w_hs) begin
                r_vec_q      <= abc;
                r_settle_cnt <= 4'd0;
            end else if (r_state == SETTLE) begin
                r_settle_cnt <= r_settle_cnt + 4'd1;
            end
        end
    end

    // Run statistics
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_err_cnt <= '0;
            r_vec_cnt <= 8'd0;
            r_cov     <= 8'd0;
            r_ff_vld  <= 1'b0;
            r_ff_vec  <= 3'd0;
        end else if (w_clear) begin
            r_err_cnt <= '0;
            r_vec_cnt <= 8'd0;
            r_cov     <= 8'd0;
            r_ff_vld  <= 1'b0;
            r_ff_vec  <= 3'd0;
        end else if (r_state == COMPARE) begin
            r_vec_cnt      <= w_vec_cnt_inc;
            r_cov[r_vec_q] <= 1'b1;
            if (w_mismatch) begin
                if (r_err_cnt != '1) r_err_cnt <= r_err_cnt + ERR_W'(1);
                if (!r_ff_vld) begin
                    r_ff_vld <= 1'b1;
                    r_ff_vec <= r_vec_q;
                end
            end
        end
    end

    assign in_ready         = (r_state == ACCEPT);
    assign busy             = (r_state == ACCEPT) || (r_state == SETTLE) || (r_state == COMPARE);
    assign done             = (r_state == DONE);
    assign pass             = (r_state == DONE) && (r_err_cnt == '0) &&
                              (!NEED_FULL_COV || (r_cov == ALL_COVERED));
    assign err_count        = r_err_cnt;
    assign vec_count        = r_vec_cnt;
    assign coverage         = r_cov;
    assign first_fail_valid = r_ff_vld;
    assign first_fail_vec   = r_ff_vec;

endmodule

// File: tb/tb_minority_resp_checker.sv
// Bench for minority_resp_checker: instance A (SETTLE=1, ERR_W=8), instance B (SETTLE=0, ERR_W=2).
// Latency: n/a.
// Backpressure: stimulus waits for in_ready and holds abc until in_ready returns.
module tb_minority_resp_checker;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start    [2];
    logic       in_valid [2];
    logic [2:0] abc      [2];
    logic [7:0] flip     [2];
    logic       y_a, y_b;

    logic       in_ready_a, busy_a, done_a, pass_a, ffv_a;
    logic [7:0] err_a, vc_a, cov_a;
    logic [2:0] ffvec_a;
    logic       in_ready_b, busy_b, done_b, pass_b, ffv_b;
    logic [1:0] err_b;
    logic [7:0] vc_b, cov_b;
    logic [2:0] ffvec_b;

    int n_cmp  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    // Golden minority by counting ones; the DUT model flips it where flip[abc] is set.
    function automatic logic gold(input logic [2:0] v);
        int ones;
        ones = int'(v[0]) + int'(v[1]) + int'(v[2]);
        return (ones < 2);
    endfunction

    assign y_a = gold(abc[0]) ^ flip[0][abc[0]];
    assign y_b = gold(abc[1]) ^ flip[1][abc[1]];

    minority_resp_checker #(.NUM_VECTORS(8), .SETTLE_CYCLES(1), .ERR_W(8)) u_a (
        .clk(clk), .rst_n(rst_n), .start(start[0]), .in_valid(in_valid[0]),
        .in_ready(in_ready_a), .abc(abc[0]), .y_dut(y_a), .busy(busy_a), .done(done_a),
        .pass(pass_a), .err_count(err_a), .vec_count(vc_a), .coverage(cov_a),
        .first_fail_valid(ffv_a), .first_fail_vec(ffvec_a)
    );

    minority_resp_checker #(.NUM_VECTORS(8), .SETTLE_CYCLES(0), .ERR_W(2)) u_b (
        .clk(clk), .rst_n(rst_n), .start(start[1]), .in_valid(in_valid[1]),
        .in_ready(in_ready_b), .abc(abc[1]), .y_dut(y_b), .busy(busy_b), .done(done_b),
        .pass(pass_b), .err_count(err_b), .vec_count(vc_b), .coverage(cov_b),
        .first_fail_valid(ffv_b), .first_fail_vec(ffvec_b)
    );

    typedef struct {
        logic        in_ready, busy, done, pass, ffv;
        logic [31:0] err;
        logic [7:0]  vc, cov;
        logic [2:0]  ffvec;
    } obs_t;

    function automatic obs_t get(input int s);
        obs_t o;
        if (s == 0) begin
            o.in_ready = in_ready_a; o.busy = busy_a; o.done = done_a; o.pass = pass_a;
            o.ffv = ffv_a; o.err = {24'd0, err_a}; o.vc = vc_a; o.cov = cov_a; o.ffvec = ffvec_a;
        end else begin
            o.in_ready = in_ready_b; o.busy = busy_b; o.done = done_b; o.pass = pass_b;
            o.ffv = ffv_b; o.err = {30'd0, err_b}; o.vc = vc_b; o.cov = cov_b; o.ffvec = ffvec_b;
        end
        return o;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic timeout(input string name);
        n_cmp++;
        n_fail++;
        $display("FAIL %s: wait bound expired", name);
    endtask

    task automatic chk_zero(input int s, input string tag);
        obs_t o;
        o = get(s);
        chk({tag, "_in_ready"}, 32'(o.in_ready), 0);
        chk({tag, "_busy"},     32'(o.busy),     0);
        chk({tag, "_done"},     32'(o.done),     0);
        chk({tag, "_pass"},     32'(o.pass),     0);
        chk({tag, "_err"},      o.err,           0);
        chk({tag, "_vc"},       32'(o.vc),       0);
        chk({tag, "_cov"},      32'(o.cov),      0);
        chk({tag, "_ffv"},      32'(o.ffv),      0);
        chk({tag, "_ffvec"},    32'(o.ffvec),    0);
    endtask

    // Start pulse; returns at the negedge of the first ACCEPT cycle.
    task automatic do_start(input int s);
        obs_t o;
        @(negedge clk);
        start[s] = 1'b1;
        @(negedge clk);
        start[s] = 1'b0;
        o = get(s);
        chk($sformatf("start%0d_busy", s), 32'(o.busy), 1);
        chk($sformatf("start%0d_done", s), 32'(o.done), 0);
        chk($sformatf("start%0d_pass", s), 32'(o.pass), 0);
        chk($sformatf("start%0d_vc", s),   32'(o.vc),   0);
        chk($sformatf("start%0d_err", s),  o.err,       0);
        chk($sformatf("start%0d_cov", s),  32'(o.cov),  0);
        chk($sformatf("start%0d_ffv", s),  32'(o.ffv),  0);
    endtask

    // Called at a negedge; waits for in_ready, offers v for one cycle, returns at the next negedge.
    task automatic send(input int s, input logic [2:0] v);
        obs_t o;
        int   n;
        n = 0;
        o = get(s);
        while (!o.in_ready && n < 100) begin
            @(negedge clk);
            n++;
            o = get(s);
        end
        if (n >= 100) timeout($sformatf("send%0d", s));
        abc[s]      = v;
        in_valid[s] = 1'b1;
        @(negedge clk);
        in_valid[s] = 1'b0;
    endtask

    task automatic wait_done(input int s);
        obs_t o;
        int   n;
        n = 0;
        o = get(s);
        while (!o.done && n < 200) begin
            @(negedge clk);
            n++;
            o = get(s);
        end
        if (n >= 200) timeout($sformatf("done_wait%0d", s));
    endtask

    task automatic run(input int s, input logic [2:0] v[8], input bit poke_start);
        obs_t o;
        do_start(s);
        for (int i = 0; i < 8; i++) begin
            send(s, v[i]);
            if (poke_start && i == 3) begin
                start[s] = 1'b1;
                @(negedge clk);
                start[s] = 1'b0;
                o = get(s);
                chk("poke_vc", 32'(o.vc), 4);
                chk("poke_busy", 32'(o.busy), 1);
            end
        end
        wait_done(s);
    endtask

    // Expected run results straight from the rules: count flipped responses, OR in seen values.
    task automatic model(input logic [2:0] v[8], input logic [7:0] mask, input int errmax,
                         output int e, output logic [7:0] cov, output logic ffv,
                         output logic [2:0] ffvec, output logic pss);
        logic y;
        e = 0; cov = 8'd0; ffv = 1'b0; ffvec = 3'd0;
        for (int i = 0; i < 8; i++) begin
            y = gold(v[i]) ^ mask[v[i]];
            if (y != gold(v[i])) begin
                if (!ffv) begin
                    ffv   = 1'b1;
                    ffvec = v[i];
                end
                e++;
            end
            cov = cov | (8'd1 << v[i]);
        end
        if (e > errmax) e = errmax;
        pss = (e == 0) && (cov == 8'hFF);
    endtask

    task automatic chk_final(input int s, input string tag, input int e, input logic [7:0] cov,
                             input logic ffv, input logic [2:0] ffvec, input logic pss);
        obs_t o;
        o = get(s);
        chk({tag, "_err"},      o.err,           32'(e));
        chk({tag, "_cov"},      32'(o.cov),      32'(cov));
        chk({tag, "_ffv"},      32'(o.ffv),      32'(ffv));
        chk({tag, "_ffvec"},    32'(o.ffvec),    32'(ffvec));
        chk({tag, "_pass"},     32'(o.pass),     32'(pss));
        chk({tag, "_vc"},       32'(o.vc),       8);
        chk({tag, "_done"},     32'(o.done),     1);
        chk({tag, "_busy"},     32'(o.busy),     0);
        chk({tag, "_in_ready"}, 32'(o.in_ready), 0);
    endtask

    typedef struct packed {
        logic [7:0]  mask;
        logic [23:0] vecs;      // element i at [3*i +: 3]
        logic [7:0]  exp_err;
        logic [7:0]  exp_cov;
        logic        exp_ffv;
        logic [2:0]  exp_ffvec;
        logic        exp_pass;
    } row_t;

    initial begin
        row_t       tbl [4];
        logic [2:0] v   [8];
        logic [2:0] t;
        int         e, idx, j;
        logic [7:0] ecov, mask;
        logic       effv, epass;
        logic [2:0] effvec;
        obs_t       o;

        // golden in order; stuck-at-0; 011 repeated instead of 111; inverting in reverse order
        tbl[0] = '{8'h00, 24'o76543210, 8'd0, 8'hFF, 1'b0, 3'd0, 1'b1};
        tbl[1] = '{8'h17, 24'o76543210, 8'd4, 8'hFF, 1'b1, 3'd0, 1'b0};
        tbl[2] = '{8'h00, 24'o36543210, 8'd0, 8'h7F, 1'b0, 3'd0, 1'b0};
        tbl[3] = '{8'hFF, 24'o01234567, 8'd8, 8'hFF, 1'b1, 3'd7, 1'b0};

        rst_n = 1'b0;
        for (int s = 0; s < 2; s++) begin
            start[s] = 1'b0; in_valid[s] = 1'b0; abc[s] = 3'd0; flip[s] = 8'h00;
        end
        repeat (3) @(negedge clk);
        chk_zero(0, "rst_a");
        chk_zero(1, "rst_b");
        rst_n = 1'b1;
        @(negedge clk);

        // Table-driven runs on instance A
        for (int r = 0; r < 4; r++) begin
            flip[0] = tbl[r].mask;
            for (int i = 0; i < 8; i++) v[i] = tbl[r].vecs[3*i +: 3];
            run(0, v, 1'b0);
            chk_final(0, $sformatf("tbl%0d", r), int'(tbl[r].exp_err), tbl[r].exp_cov,
                      tbl[r].exp_ffv, tbl[r].exp_ffvec, tbl[r].exp_pass);
        end

        // Reset during SETTLE of the fourth vector, then a clean run
        flip[0] = 8'h00;
        do_start(0);
        for (int i = 0; i < 4; i++) send(0, 3'(i));
        o = get(0);
        chk("abort_vc_before", 32'(o.vc), 3);
        chk("abort_busy_before", 32'(o.busy), 1);
        rst_n = 1'b0;
        #1;
        chk_zero(0, "abort");
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        for (int i = 0; i < 8; i++) v[i] = 3'(i);
        run(0, v, 1'b0);
        chk_final(0, "after_abort", 0, 8'hFF, 1'b0, 3'd0, 1'b1);

        // Back-to-back with in_valid held high on instance B (no settle)
        flip[1] = 8'h00;
        do_start(1);
        in_valid[1] = 1'b1;
        idx = 0;
        for (int k = 0; k < 18; k++) begin
            o = get(1);
            chk($sformatf("b2b_rdy_%0d", k),  32'(o.in_ready), 32'((k < 16) && (k % 2 == 0)));
            chk($sformatf("b2b_vc_%0d", k),   32'(o.vc),       32'((k < 16) ? k / 2 : 8));
            chk($sformatf("b2b_done_%0d", k), 32'(o.done),     32'(k >= 16));
            if (o.in_ready && idx < 8) begin
                abc[1] = 3'(idx);
                idx++;
            end
            @(negedge clk);
        end
        in_valid[1] = 1'b0;
        chk_final(1, "b2b", 0, 8'hFF, 1'b0, 3'd0, 1'b1);

        // Saturating 2-bit error counter with an inverting DUT; start mid-run is ignored
        flip[1] = 8'hFF;
        for (int i = 0; i < 8; i++) v[i] = 3'(i);
        run(1, v, 1'b1);
        chk_final(1, "sat", 3, 8'hFF, 1'b1, 3'd0, 1'b0);

        // Randomized runs against the reference model
        for (int r = 0; r < 24; r++) begin
            int s;
            s = r % 2;
            if ($urandom_range(0, 1) == 0) begin
                for (int i = 0; i < 8; i++) v[i] = 3'(i);
                for (int i = 7; i > 0; i--) begin
                    j = $urandom_range(0, i);
                    t = v[i]; v[i] = v[j]; v[j] = t;
                end
            end else begin
                for (int i = 0; i < 8; i++) v[i] = 3'($urandom_range(0, 7));
            end
            mask = ($urandom_range(0, 2) == 0) ? 8'h00 : 8'($urandom);
            flip[s] = mask;
            run(s, v, 1'b0);
            model(v, mask, (s == 0) ? 255 : 3, e, ecov, effv, effvec, epass);
            chk_final(s, $sformatf("rnd%0d", r), e, ecov, effv, effvec, epass);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
